// File: rtl/alu24_exec.sv
// alu24_exec -- execution unit driven by the 4-bit ALU control Operation code.
//
// Latches operands and operation on Start. Logic, add/sub, set-less-than and
// shift-left complete in one clock; MUL is an iterative shift-add over WIDTH
// clocks. All outputs are registered.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-high reset
//   Start      in   request strobe, sampled only when Busy=0
//   Operation  in   [3:0] operation code
//   A, B       in   [WIDTH-1:0] operands (B[4:0] is the shift amount)
//   Busy       out  multi-cycle MUL in progress, Start ignored
//   Done       out  one-cycle pulse, Result/flags valid from this cycle
//   Result     out  [WIDTH-1:0] registered result, held until next Done
//   Zero       out  registered (Result == 0)
//   Overflow   out  registered, op-qualified overflow flag
module alu24_exec #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLT = 4'b0011,
        OP_MUL = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SUB = 4'b1010
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Registered state
    state_e                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_result;
    logic                   r_zero;
    logic                   r_ovf;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_count;

    // Next-state values
    state_e                 w_next_state;
    logic                   w_busy_d;
    logic                   w_done_d;
    logic [WIDTH-1:0]       w_result_d;
    logic                   w_zero_d;
    logic                   w_ovf_d;
    logic [2*WIDTH-1:0]     w_mcand_d;
    logic [WIDTH-1:0]       w_mplier_d;
    logic [2*WIDTH-1:0]     w_acc_d;
    logic [CNT_W-1:0]       w_count_d;

    // Single-cycle datapath
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_alu_result;
    logic                   w_alu_ovf;
    logic [4:0]             w_shamt;

    // Shift-add step
    logic [2*WIDTH-1:0]     w_acc_sum;
    logic                   w_mul_last;

    assign w_sum   = A + B;
    assign w_diff  = A - B;
    assign w_shamt = B[4:0];

    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (Operation)
            OP_AND: w_alu_result = A & B;
            OP_OR:  w_alu_result = A | B;
            OP_XOR: w_alu_result = A ^ B;
            OP_ADD: begin
                w_alu_result = w_sum;
                // Same operand signs, result sign differs.
                w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                // As for ADD, with B's sign inverted.
                w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}},
                                    ($signed(A) < $signed(B))};
            OP_SLL: w_alu_result = (int'(w_shamt) >= WIDTH) ? '0
                                                           : (A << w_shamt);
            default: begin
                w_alu_result = '0;
                w_alu_ovf    = 1'b0;
            end
        endcase
    end

    assign w_acc_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_count == CNT_W'(WIDTH - 1));

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_busy_d     = 1'b0;
        w_done_d     = 1'b0;
        w_result_d   = r_result;
        w_zero_d     = r_zero;
        w_ovf_d      = r_ovf;
        w_mcand_d    = r_mcand;
        w_mplier_d   = r_mplier;
        w_acc_d      = r_acc;
        w_count_d    = r_count;

        case (r_state)
            // DONE accepts a new Start exactly like IDLE (back-to-back issue).
            S_IDLE, S_DONE: begin
                w_next_state = S_IDLE;
                if (Start) begin
                    if (Operation == OP_MUL) begin
                        w_next_state = S_MUL;
                        w_busy_d     = 1'b1;
                        w_mcand_d    = {{WIDTH{1'b0}}, A};
                        w_mplier_d   = B;
                        w_acc_d      = '0;
                        w_count_d    = '0;
                    end else begin
                        w_next_state = S_DONE;
                        w_done_d     = 1'b1;
                        w_result_d   = w_alu_result;
                        w_zero_d     = (w_alu_result == '0);
                        w_ovf_d      = w_alu_ovf;
                    end
                end
            end
            S_MUL: begin
                // Start, A, B and Operation are ignored here; only latched
                // operands feed the iteration.
                w_acc_d    = w_acc_sum;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_count_d  = r_count + 1'b1;
                if (w_mul_last) begin
                    w_next_state = S_DONE;
                    w_done_d     = 1'b1;
                    w_result_d   = w_acc_sum[WIDTH-1:0];
                    w_zero_d     = (w_acc_sum[WIDTH-1:0] == '0);
                    w_ovf_d      = |w_acc_sum[2*WIDTH-1:WIDTH];
                end else begin
                    w_busy_d     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_result <= w_result_d;
            r_zero   <= w_zero_d;
            r_ovf    <= w_ovf_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_acc    <= w_acc_d;
            r_count  <= w_count_d;
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_alu24_exec.sv
// tb_alu24_exec -- directed self-checking bench for alu24_exec.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alu24_exec;

    localparam int WIDTH = 24;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic             Clock;
    logic             Reset;
    logic             Start;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu24_exec #(.WIDTH(WIDTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Operation (Operation),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Drive Start for one edge; returns positioned in cycle 1.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        Start     = 1'b1;
        Operation = op;
        A         = a;
        B         = b;
        step();
        Start     = 1'b0;
    endtask

    // Single-cycle op: Done/Result/flags in cycle 1, Busy never high.
    task automatic single(input string tag, input logic [3:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_r, input logic exp_ovf);
        issue(op, a, b);
        check({tag, ".done"}, 32'(Done), 32'd1);
        check({tag, ".busy"}, 32'(Busy), 32'd0);
        check({tag, ".res"},  32'(Result), 32'(exp_r));
        check({tag, ".zero"}, 32'(Zero), 32'(exp_r == '0));
        check({tag, ".ovf"},  32'(Overflow), 32'(exp_ovf));
    endtask

    // MUL: Busy cycles 1..24 with Result held, Done in cycle 25.
    task automatic mul(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_r, input logic exp_ovf,
                       input bit repulse);
        logic [WIDTH-1:0] held;
        int               bad_busy;
        held     = Result;
        bad_busy = 0;
        issue(OP_MUL, a, b);
        for (int c = 1; c <= 24; c++) begin
            if (Busy !== 1'b1 || Done !== 1'b0 || Result !== held) bad_busy++;
            if (repulse && c == 5) begin
                Start     = 1'b1;
                Operation = OP_ADD;
                A         = 24'h000001;
                B         = 24'h000002;
            end else begin
                Start = 1'b0;
                A     = 24'hA5A5A5 ^ 24'(c);
                B     = 24'h5A5A5A;
            end
            step();
        end
        Start = 1'b0;
        check({tag, ".busy_window"}, 32'(bad_busy), 32'd0);
        check({tag, ".done"}, 32'(Done), 32'd1);
        check({tag, ".busy25"}, 32'(Busy), 32'd0);
        check({tag, ".res"},  32'(Result), 32'(exp_r));
        check({tag, ".zero"}, 32'(Zero), 32'(exp_r == '0));
        check({tag, ".ovf"},  32'(Overflow), 32'(exp_ovf));
        step();
        check({tag, ".done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int done_seen;
        Reset     = 1'b1;
        Start     = 1'b0;
        Operation = OP_AND;
        A         = '0;
        B         = '0;
        step();
        step();
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.res",  32'(Result), 32'd0);
        check("rst.zero", 32'(Zero), 32'd1);
        check("rst.ovf",  32'(Overflow), 32'd0);
        Reset = 1'b0;
        step();

        // Signed overflow on ADD.
        single("add_ovf", OP_ADD, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b1);

        // SUB then SLT issued in cycle 1 (back-to-back).
        Start = 1'b1; Operation = OP_SUB; A = 24'h123456; B = 24'h123456;
        step();
        check("sub.done", 32'(Done), 32'd1);
        check("sub.zero", 32'(Zero), 32'd1);
        check("sub.ovf",  32'(Overflow), 32'd0);
        Start = 1'b1; Operation = OP_SLT; A = 24'hFFFFFB; B = 24'h000003;
        step();
        Start = 1'b0;
        check("slt.done", 32'(Done), 32'd1);
        check("slt.res",  32'(Result), 32'h000001);
        step();
        check("slt.done_pulse", 32'(Done), 32'd0);

        single("sub_ovf", OP_SUB, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b1);
        single("slt_false", OP_SLT, 24'h000003, 24'hFFFFFB, 24'h000000, 1'b0);
        single("and", OP_AND, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0);
        single("or",  OP_OR,  24'hF0F0F0, 24'h0F0000, 24'hFFF0F0, 1'b0);
        single("xor", OP_XOR, 24'hFFFF00, 24'h0F0F0F, 24'hF0F00F, 1'b0);
        single("sll23", OP_SLL, 24'h000001, 24'h000017, 24'h800000, 1'b0);
        single("sll30", OP_SLL, 24'h000001, 24'h00001E, 24'h000000, 1'b0);
        single("sll24", OP_SLL, 24'h000003, 24'h000018, 24'h000000, 1'b0);
        // Only B[4:0] is the shift amount: 0x20 shifts by 0.
        single("sll_hi", OP_SLL, 24'h000003, 24'h000020, 24'h000003, 1'b0);
        single("bad_op", OP_BAD, 24'h7FFFFF, 24'h000001, 24'h000000, 1'b0);
        step();

        // 0x1000 * 0x1000 = 0x1_000000: low bits zero, high bits nonzero.
        mul("mul_big", 24'h001000, 24'h001000, 24'h000000, 1'b1, 1'b0);
        // 0x123 * 0x45 = 291 * 69 = 20079 = 0x4E6F.
        mul("mul_small", 24'h000123, 24'h000045, 24'h004E6F, 1'b0, 1'b0);
        // Start re-pulsed in cycle 5 with ADD is dropped; 0xABC*0x100.
        mul("mul_repulse", 24'h000ABC, 24'h000100, 24'h0ABC00, 1'b0, 1'b1);

        // Reset in cycle 10 of a MUL aborts it.
        issue(OP_MUL, 24'h001000, 24'h001000);
        for (int c = 1; c < 10; c++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort.busy", 32'(Busy), 32'd0);
        check("abort.res",  32'(Result), 32'd0);
        check("abort.zero", 32'(Zero), 32'd1);
        check("abort.ovf",  32'(Overflow), 32'd0);
        done_seen = 0;
        for (int c = 11; c <= 30; c++) begin
            if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
            step();
        end
        check("abort.no_done", 32'(done_seen), 32'd0);

        // Reset and Start together: Start lost.
        single("pre_rs", OP_ADD, 24'h000010, 24'h000020, 24'h000030, 1'b0);
        Reset = 1'b1;
        issue(OP_ADD, 24'h000001, 24'h000001);
        Reset = 1'b0;
        check("rs.done", 32'(Done), 32'd0);
        check("rs.res",  32'(Result), 32'd0);
        step();
        check("rs.done2", 32'(Done), 32'd0);
        check("rs.res2",  32'(Result), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
